// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file plus trap/MRET sequencer; arbitrates exceptions,
// level interrupts and MRET, and hands the new PC to fetch over valid/ready.
module csr_trap_unit #(
    parameter int               XLEN        = 64,
    parameter int               NUM_IRQ     = 16,
    parameter int               VEC_EN      = 1,
    parameter logic [XLEN-1:0]  MTVEC_RESET = '0
) (
    input  logic                CLK,
    input  logic                RESET_N,
    input  logic                CSR_EN,
    input  logic [1:0]          CSR_OP,
    input  logic [11:0]         CSR_ADDR,
    input  logic [XLEN-1:0]     CSR_WDATA,
    output logic [XLEN-1:0]     CSR_RDATA,
    output logic                CSR_ILLEGAL,
    input  logic                RETIRE,
    input  logic                EXC_REQ,
    input  logic [XLEN-2:0]     EXC_CAUSE,
    input  logic [XLEN-1:0]     EXC_PC,
    input  logic [XLEN-1:0]     EXC_TVAL,
    input  logic [XLEN-1:0]     INT_PC,
    input  logic [NUM_IRQ-1:0]  IRQ,
    input  logic                MRET_REQ,
    output logic                REDIRECT_VALID,
    input  logic                REDIRECT_READY,
    output logic [XLEN-1:0]     REDIRECT_PC,
    output logic                BUSY,
    output logic [1:0]          PRIV
);

    localparam int IDXW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MTVAL    = 12'h343;
    localparam logic [11:0] A_MIP      = 12'h344;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MINSTRET = 12'hB02;

    // With vectoring disabled the mode field is hardwired to direct.
    localparam logic [XLEN-1:0] MTVEC_WMASK = (VEC_EN != 0) ? '1 : ~XLEN'(3);

    typedef enum logic [1:0] {IDLE, SAVE, REDIRECT} state_t;

    state_t                 state;
    logic                   status_mie;
    logic                   status_mpie;
    logic [1:0]             status_mpp;
    logic [NUM_IRQ-1:0]     mie_q;
    logic [NUM_IRQ-1:0]     mip_q;
    logic [XLEN-1:0]        mtvec_q;
    logic [XLEN-1:0]        mscratch_q;
    logic [XLEN-1:0]        mepc_q;
    logic [XLEN-1:0]        mcause_q;
    logic [XLEN-1:0]        mtval_q;
    logic [XLEN-1:0]        mcycle_q;
    logic [XLEN-1:0]        minstret_q;
    logic                   trap_irq_q;
    logic [IDXW-1:0]        trap_idx_q;

    logic                   mapped;
    logic                   ro_write;
    logic [XLEN-1:0]        wval;
    logic                   is_idle;
    logic                   irq_pend;
    logic [IDXW-1:0]        irq_idx;
    logic [NUM_IRQ-1:0]     irq_act;
    logic                   take_exc;
    logic                   take_irq;
    logic                   take_mret;
    logic                   csr_we;
    logic [XLEN-1:0]        trap_target;

    // Read mux reflects the pre-update value of the addressed CSR.
    always_comb begin
        CSR_RDATA = '0;
        mapped    = 1'b1;
        case (CSR_ADDR)
            A_MSTATUS: begin
                CSR_RDATA[3]     = status_mie;
                CSR_RDATA[7]     = status_mpie;
                CSR_RDATA[12:11] = status_mpp;
            end
            A_MIE:      CSR_RDATA[NUM_IRQ-1:0] = mie_q;
            A_MTVEC:    CSR_RDATA = mtvec_q;
            A_MSCRATCH: CSR_RDATA = mscratch_q;
            A_MEPC:     CSR_RDATA = mepc_q;
            A_MCAUSE:   CSR_RDATA = mcause_q;
            A_MTVAL:    CSR_RDATA = mtval_q;
            A_MIP:      CSR_RDATA[NUM_IRQ-1:0] = mip_q;
            A_MCYCLE:   CSR_RDATA = mcycle_q;
            A_MINSTRET: CSR_RDATA = minstret_q;
            default:    mapped = 1'b0;
        endcase
    end

    always_comb begin
        case (CSR_OP)
            2'b01:   wval = CSR_WDATA;
            2'b10:   wval = CSR_RDATA | CSR_WDATA;
            2'b11:   wval = CSR_RDATA & ~CSR_WDATA;
            default: wval = CSR_RDATA;
        endcase
    end

    // Set/clear of mip with a zero mask is a pure read and stays legal.
    assign ro_write    = (CSR_ADDR == A_MIP) &&
                         ((CSR_OP == 2'b01) || (CSR_OP[1] && (CSR_WDATA != '0)));
    assign CSR_ILLEGAL = CSR_EN && (!mapped || ro_write);

    assign irq_act  = mip_q & mie_q;
    assign irq_pend = status_mie && (irq_act != '0);

    // Scan from the top so the lowest active index is the last assignment.
    always_comb begin
        irq_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_act[i]) irq_idx = IDXW'(i);
        end
    end

    assign is_idle   = (state == IDLE);
    assign take_exc  = is_idle && EXC_REQ;
    assign take_irq  = is_idle && !EXC_REQ && irq_pend;
    assign take_mret = is_idle && !EXC_REQ && !irq_pend && MRET_REQ;
    assign csr_we    = CSR_EN && is_idle && !(take_exc || take_irq || take_mret) &&
                       (CSR_OP != 2'b00) && !CSR_ILLEGAL;
    assign BUSY      = !is_idle;

    assign trap_target = {mtvec_q[XLEN-1:2], 2'b00} +
                         ((trap_irq_q && (mtvec_q[1:0] == 2'b01)) ?
                          (XLEN'(trap_idx_q) << 2) : '0);

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state          <= IDLE;
            status_mie     <= 1'b0;
            status_mpie    <= 1'b0;
            status_mpp     <= 2'b00;
            mie_q          <= '0;
            mip_q          <= '0;
            mtvec_q        <= MTVEC_RESET & MTVEC_WMASK;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
            mcycle_q       <= '0;
            minstret_q     <= '0;
            trap_irq_q     <= 1'b0;
            trap_idx_q     <= '0;
            PRIV           <= 2'b11;
            REDIRECT_VALID <= 1'b0;
            REDIRECT_PC    <= '0;
        end else begin
            mip_q <= IRQ;

            if (csr_we && CSR_ADDR == A_MCYCLE)   mcycle_q <= wval;
            else                                  mcycle_q <= mcycle_q + 1'b1;
            if (csr_we && CSR_ADDR == A_MINSTRET) minstret_q <= wval;
            else if (RETIRE)                      minstret_q <= minstret_q + 1'b1;

            if (csr_we) begin
                case (CSR_ADDR)
                    A_MSTATUS: begin
                        status_mie  <= wval[3];
                        status_mpie <= wval[7];
                        if (wval[12:11] == 2'b00 || wval[12:11] == 2'b11)
                            status_mpp <= wval[12:11];
                    end
                    A_MIE:      mie_q      <= wval[NUM_IRQ-1:0];
                    A_MTVEC:    mtvec_q    <= wval & MTVEC_WMASK;
                    A_MSCRATCH: mscratch_q <= wval;
                    A_MEPC:     mepc_q     <= {wval[XLEN-1:2], 2'b00};
                    A_MCAUSE:   mcause_q   <= wval;
                    A_MTVAL:    mtval_q    <= wval;
                    default: ;
                endcase
            end

            case (state)
                IDLE: begin
                    if (take_exc) begin
                        mepc_q     <= {EXC_PC[XLEN-1:2], 2'b00};
                        mcause_q   <= {1'b0, EXC_CAUSE};
                        mtval_q    <= EXC_TVAL;
                        trap_irq_q <= 1'b0;
                        state      <= SAVE;
                    end else if (take_irq) begin
                        mepc_q     <= {INT_PC[XLEN-1:2], 2'b00};
                        mcause_q   <= {1'b1, (XLEN-1)'(irq_idx)};
                        mtval_q    <= '0;
                        trap_irq_q <= 1'b1;
                        trap_idx_q <= irq_idx;
                        state      <= SAVE;
                    end else if (take_mret) begin
                        status_mie     <= status_mpie;
                        status_mpie    <= 1'b1;
                        PRIV           <= status_mpp;
                        status_mpp     <= 2'b00;
                        REDIRECT_PC    <= mepc_q;
                        REDIRECT_VALID <= 1'b1;
                        state          <= REDIRECT;
                    end
                end
                SAVE: begin
                    status_mpie    <= status_mie;
                    status_mie     <= 1'b0;
                    status_mpp     <= PRIV;
                    PRIV           <= 2'b11;
                    REDIRECT_PC    <= trap_target;
                    REDIRECT_VALID <= 1'b1;
                    state          <= REDIRECT;
                end
                REDIRECT: begin
                    if (REDIRECT_READY) begin
                        REDIRECT_VALID <= 1'b0;
                        state          <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csr_trap_unit.sv
// Directed bench for csr_trap_unit: CSR access table, then trap, interrupt,
// MRET, counter and reset-abort sequences.
module tb_csr_trap_unit;

    localparam int XLEN = 64;
    localparam int NIRQ = 16;

    logic              CLK = 1'b0;
    logic              RESET_N;
    logic              CSR_EN;
    logic [1:0]        CSR_OP;
    logic [11:0]       CSR_ADDR;
    logic [XLEN-1:0]   CSR_WDATA;
    logic [XLEN-1:0]   CSR_RDATA;
    logic              CSR_ILLEGAL;
    logic              RETIRE;
    logic              EXC_REQ;
    logic [XLEN-2:0]   EXC_CAUSE;
    logic [XLEN-1:0]   EXC_PC;
    logic [XLEN-1:0]   EXC_TVAL;
    logic [XLEN-1:0]   INT_PC;
    logic [NIRQ-1:0]   IRQ;
    logic              MRET_REQ;
    logic              REDIRECT_VALID;
    logic              REDIRECT_READY;
    logic [XLEN-1:0]   REDIRECT_PC;
    logic              BUSY;
    logic [1:0]        PRIV;

    csr_trap_unit #(
        .XLEN(XLEN), .NUM_IRQ(NIRQ), .VEC_EN(1), .MTVEC_RESET(64'h8000_0000)
    ) dut (
        .CLK(CLK), .RESET_N(RESET_N), .CSR_EN(CSR_EN), .CSR_OP(CSR_OP),
        .CSR_ADDR(CSR_ADDR), .CSR_WDATA(CSR_WDATA), .CSR_RDATA(CSR_RDATA),
        .CSR_ILLEGAL(CSR_ILLEGAL), .RETIRE(RETIRE), .EXC_REQ(EXC_REQ),
        .EXC_CAUSE(EXC_CAUSE), .EXC_PC(EXC_PC), .EXC_TVAL(EXC_TVAL),
        .INT_PC(INT_PC), .IRQ(IRQ), .MRET_REQ(MRET_REQ),
        .REDIRECT_VALID(REDIRECT_VALID), .REDIRECT_READY(REDIRECT_READY),
        .REDIRECT_PC(REDIRECT_PC), .BUSY(BUSY), .PRIV(PRIV)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [1:0]      op;
        logic [11:0]     addr;
        logic [XLEN-1:0] wdata;
        logic            ill;
        logic [XLEN-1:0] exp;
    } vec_t;

    vec_t vecs[15];

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string nm, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk_csr(input string nm, input logic [11:0] a, input logic [XLEN-1:0] exp);
        CSR_ADDR = a;
        #1;
        chk(nm, CSR_RDATA, exp);
    endtask

    task automatic csr_op(input logic [1:0] op, input logic [11:0] a, input logic [XLEN-1:0] d);
        CSR_EN = 1'b1; CSR_OP = op; CSR_ADDR = a; CSR_WDATA = d;
        tick();
        CSR_EN = 1'b0; CSR_OP = 2'b00;
    endtask

    task automatic finish_redirect();
        REDIRECT_READY = 1'b1;
        tick();
        REDIRECT_READY = 1'b0;
    endtask

    initial begin
        RESET_N = 1'b0; CSR_EN = 0; CSR_OP = 0; CSR_ADDR = 0; CSR_WDATA = 0;
        RETIRE = 0; EXC_REQ = 0; EXC_CAUSE = 0; EXC_PC = 0; EXC_TVAL = 0;
        INT_PC = 0; IRQ = 0; MRET_REQ = 0; REDIRECT_READY = 0;

        // {op, addr, wdata, illegal, readback}
        vecs[0]  = '{2'b01, 12'h340, 64'hF0,        1'b0, 64'hF0};
        vecs[1]  = '{2'b10, 12'h340, 64'h0F,        1'b0, 64'hFF};
        vecs[2]  = '{2'b11, 12'h340, 64'h3C,        1'b0, 64'hC3};
        vecs[3]  = '{2'b01, 12'h344, 64'h55,        1'b1, 64'h0};
        vecs[4]  = '{2'b01, 12'h7FF, 64'h1,         1'b1, 64'h0};
        vecs[5]  = '{2'b00, 12'h340, 64'h0,         1'b0, 64'hC3};
        vecs[6]  = '{2'b10, 12'h344, 64'h0,         1'b0, 64'h0};
        vecs[7]  = '{2'b01, 12'h300, 64'hFFFF_FFFF, 1'b0, 64'h1888};
        vecs[8]  = '{2'b01, 12'h300, 64'h0800,      1'b0, 64'h1800};
        vecs[9]  = '{2'b01, 12'h300, 64'h0,         1'b0, 64'h0};
        vecs[10] = '{2'b01, 12'h341, 64'h1237,      1'b0, 64'h1234};
        vecs[11] = '{2'b01, 12'h305, 64'h4001,      1'b0, 64'h4001};
        vecs[12] = '{2'b01, 12'h304, 64'hFFFF_FFFF, 1'b0, 64'hFFFF};
        vecs[13] = '{2'b11, 12'h304, 64'hFFCF,      1'b0, 64'h30};
        vecs[14] = '{2'b10, 12'h344, 64'h1,         1'b1, 64'h0};

        repeat (2) tick();
        chk("rst_valid", 64'(REDIRECT_VALID), 64'h0);
        chk("rst_pc", REDIRECT_PC, 64'h0);
        chk("rst_priv", 64'(PRIV), 64'h3);
        chk("rst_busy", 64'(BUSY), 64'h0);
        RESET_N = 1'b1;
        tick();
        chk_csr("rst_mtvec", 12'h305, 64'h8000_0000);
        chk_csr("rst_mstatus", 12'h300, 64'h0);

        for (int i = 0; i < 15; i++) begin
            CSR_EN = 1'b1; CSR_OP = vecs[i].op; CSR_ADDR = vecs[i].addr; CSR_WDATA = vecs[i].wdata;
            #1;
            chk($sformatf("vec%0d_ill", i), 64'(CSR_ILLEGAL), 64'(vecs[i].ill));
            tick();
            CSR_EN = 1'b0; CSR_OP = 2'b00;
            chk_csr($sformatf("vec%0d_rd", i), vecs[i].addr, vecs[i].exp);
        end
        chk_csr("mscratch_kept", 12'h340, 64'hC3);

        // Synchronous exception, direct target even with vectored mtvec.
        csr_op(2'b01, 12'h300, 64'h8);
        EXC_REQ = 1'b1; EXC_CAUSE = 63'd2; EXC_PC = 64'h1002; EXC_TVAL = 64'hDEAD;
        tick();
        EXC_REQ = 1'b0;
        chk("exc_busy_save", 64'(BUSY), 64'h1);
        chk("exc_valid_save", 64'(REDIRECT_VALID), 64'h0);
        tick();
        chk("exc_valid", 64'(REDIRECT_VALID), 64'h1);
        chk("exc_pc", REDIRECT_PC, 64'h4000);
        chk_csr("exc_mepc", 12'h341, 64'h1000);
        chk_csr("exc_mcause", 12'h342, 64'h2);
        chk_csr("exc_mtval", 12'h343, 64'hDEAD);
        chk_csr("exc_mstatus", 12'h300, 64'h1880);
        finish_redirect();
        chk("exc_done_valid", 64'(REDIRECT_VALID), 64'h0);
        chk("exc_done_busy", 64'(BUSY), 64'h0);

        // Vectored interrupt: lowest active line 4 -> base + 16.
        csr_op(2'b01, 12'h300, 64'h1808);
        INT_PC = 64'h2002; IRQ = 16'h0030;
        tick();
        chk("irq_not_yet", 64'(BUSY), 64'h0);
        tick();
        chk("irq_save", 64'(BUSY), 64'h1);
        tick();
        chk("irq_valid", 64'(REDIRECT_VALID), 64'h1);
        chk("irq_pc", REDIRECT_PC, 64'h4010);
        chk_csr("irq_mcause", 12'h342, 64'h8000_0000_0000_0004);
        chk_csr("irq_mepc", 12'h341, 64'h2000);
        chk_csr("irq_mtval", 12'h343, 64'h0);
        chk_csr("irq_mstatus", 12'h300, 64'h1880);
        finish_redirect();
        repeat (3) tick();
        chk("irq_masked_busy", 64'(BUSY), 64'h0);
        chk("irq_masked_valid", 64'(REDIRECT_VALID), 64'h0);

        // Everything at once: exception wins; redirect held under back-pressure.
        csr_op(2'b01, 12'h300, 64'h1808);
        EXC_REQ = 1'b1; EXC_CAUSE = 63'd5; EXC_PC = 64'h3000; EXC_TVAL = 64'h77; MRET_REQ = 1'b1;
        tick();
        EXC_REQ = 1'b0; MRET_REQ = 1'b0;
        chk_csr("all_mcause", 12'h342, 64'h5);
        tick();
        CSR_EN = 1'b1; CSR_OP = 2'b01; CSR_ADDR = 12'h340; CSR_WDATA = 64'h999;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("hold%0d_valid", k), 64'(REDIRECT_VALID), 64'h1);
            chk($sformatf("hold%0d_pc", k), REDIRECT_PC, 64'h4000);
            chk($sformatf("hold%0d_busy", k), 64'(BUSY), 64'h1);
            tick();
        end
        CSR_EN = 1'b0; CSR_OP = 2'b00; IRQ = '0;
        finish_redirect();
        chk_csr("busy_write_dropped", 12'h340, 64'hC3);

        MRET_REQ = 1'b1;
        tick();
        MRET_REQ = 1'b0;
        chk("mret_valid", 64'(REDIRECT_VALID), 64'h1);
        chk("mret_pc", REDIRECT_PC, 64'h3000);
        chk("mret_priv", 64'(PRIV), 64'h3);
        chk_csr("mret_mstatus", 12'h300, 64'h88);
        finish_redirect();
        MRET_REQ = 1'b1;
        tick();
        MRET_REQ = 1'b0;
        chk("mret2_priv_u", 64'(PRIV), 64'h0);
        finish_redirect();

        // Counters: write beats increment, wrap at 2^XLEN.
        csr_op(2'b01, 12'hB00, 64'd5);
        chk_csr("mcycle_wr", 12'hB00, 64'd5);
        tick();
        chk_csr("mcycle_inc", 12'hB00, 64'd6);
        csr_op(2'b01, 12'hB00, '1);
        chk_csr("mcycle_max", 12'hB00, '1);
        tick();
        chk_csr("mcycle_wrap", 12'hB00, 64'd0);
        csr_op(2'b01, 12'hB02, 64'd0);
        RETIRE = 1'b1; tick(); tick();
        RETIRE = 1'b0; tick();
        RETIRE = 1'b1; tick();
        RETIRE = 1'b0;
        chk_csr("minstret_cnt", 12'hB02, 64'd3);
        RETIRE = 1'b1;
        csr_op(2'b01, 12'hB02, 64'd10);
        RETIRE = 1'b0;
        chk_csr("minstret_wr_prio", 12'hB02, 64'd10);

        // Asynchronous reset in SAVE aborts the trap.
        EXC_REQ = 1'b1; EXC_CAUSE = 63'd7; EXC_PC = 64'h5000;
        tick();
        EXC_REQ = 1'b0;
        chk("abort_in_save", 64'(BUSY), 64'h1);
        #2 RESET_N = 1'b0;
        #1;
        chk("abort_busy", 64'(BUSY), 64'h0);
        chk("abort_valid", 64'(REDIRECT_VALID), 64'h0);
        chk("abort_pc", REDIRECT_PC, 64'h0);
        chk("abort_priv", 64'(PRIV), 64'h3);
        chk_csr("abort_mtvec", 12'h305, 64'h8000_0000);
        chk_csr("abort_mepc", 12'h341, 64'h0);
        tick();
        RESET_N = 1'b1;
        tick(); tick();
        chk("abort_no_redirect", 64'(REDIRECT_VALID), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
